// File: rtl/isa_target_pkg.sv
// Shared definitions for the ISA I/O target: register map, STATUS layout and FSM states.
package isa_target_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int unsigned ST_EMPTY = 8;
  localparam int unsigned ST_FULL  = 9;
  localparam int unsigned ST_OVF   = 10;
  localparam int unsigned ST_UNF   = 11;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  function automatic logic [15:0] status_word(input logic [7:0] cnt, input logic empty,
                                              input logic full, input logic ovf,
                                              input logic unf);
    logic [15:0] w;
    w           = '0;
    w[7:0]      = cnt;
    w[ST_EMPTY] = empty;
    w[ST_FULL]  = full;
    w[ST_OVF]   = ovf;
    w[ST_UNF]   = unf;
    return w;
  endfunction

endpackage

// File: rtl/isa_target_fifo.sv
// Synchronous loopback FIFO; overflowing pushes and underflowing pops are ignored here.
module isa_target_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Flush overrides any simultaneous pop so the FIFO always ends up empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/isa_io_target.sv
// ISA I/O target: strobe synchronizers, address decode, bus FSM and the four-register window.
module isa_io_target
  import isa_target_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0220,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] D_in,
  output logic [15:0] D_out,
  output logic        D_oe,
  input  logic        IOW_n,
  input  logic        IOR_n,
  input  logic        AEN,
  output logic        IRQ
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  state_t          state_n;
  logic [2:0]      ior_sync;
  logic [2:0]      iow_sync;
  logic [1:0]      settle;
  logic            ior_armed;
  logic            iow_armed;
  logic            ior_fall;
  logic            ior_rise;
  logic            iow_fall;
  logic            iow_rise;
  logic            decode_hit;
  logic            rd_hit;
  logic            wr_hit;
  logic            capture_rd;
  logic            capture_wr;
  logic            rd_done;
  logic            wr_commit;
  logic [1:0]      off_q;
  logic [15:0]     scratch;
  logic            irq_en;
  logic            ovf;
  logic            unf;
  logic [15:0]     rd_word;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic [15:0]     fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  // A strobe only arms once it has been seen deasserted after the pipeline holds real
  // samples, so a strobe held low across reset release never produces an assertion edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ior_sync  <= '1;
      iow_sync  <= '1;
      settle    <= '0;
      ior_armed <= 1'b0;
      iow_armed <= 1'b0;
    end else begin
      ior_sync  <= {ior_sync[1:0], IOR_n};
      iow_sync  <= {iow_sync[1:0], IOW_n};
      settle    <= {settle[0], 1'b1};
      ior_armed <= ior_armed | (settle[1] & ior_sync[1]);
      iow_armed <= iow_armed | (settle[1] & iow_sync[1]);
    end
  end

  always_comb begin
    ior_fall   = ior_armed & ior_sync[2] & ~ior_sync[1];
    iow_fall   = iow_armed & iow_sync[2] & ~iow_sync[1];
    ior_rise   = ~ior_sync[2] & ior_sync[1];
    iow_rise   = ~iow_sync[2] & iow_sync[1];
    decode_hit = (A[15:2] == BASE_ADDR[15:2]) & ~AEN;
    rd_hit     = ior_fall & iow_sync[1] & decode_hit;
    wr_hit     = iow_fall & ior_sync[1] & decode_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (rd_hit)      state_n = RD;
        else if (wr_hit) state_n = WR;
      end
      RD:      if (ior_rise) state_n = IDLE;
      WR:      if (iow_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    D_oe       = (state == RD);
    capture_rd = (state == IDLE) & rd_hit;
    capture_wr = (state == IDLE) & ~rd_hit & wr_hit;
    rd_done    = (state == RD) & ior_rise;
    wr_commit  = (state == WR) & iow_rise;
  end

  always_comb begin
    rd_word = '0;
    case (A[1:0])
      REG_DATA:    rd_word = fifo_empty ? '0 : fifo_head;
      REG_STATUS:  rd_word = status_word(8'(fifo_count), fifo_empty, fifo_full, ovf, unf);
      REG_CTRL:    rd_word[CTRL_IRQ_EN] = irq_en;
      REG_SCRATCH: rd_word = scratch;
      default:     rd_word = '0;
    endcase
  end

  always_comb begin
    fifo_push  = wr_commit & (off_q == REG_DATA);
    fifo_pop   = rd_done & (off_q == REG_DATA);
    fifo_flush = wr_commit & (off_q == REG_CTRL) & D_in[CTRL_FLUSH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q   <= '0;
      D_out   <= '0;
      scratch <= '0;
      irq_en  <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      IRQ     <= 1'b0;
    end else begin
      if (capture_rd | capture_wr) off_q <= A[1:0];
      if (capture_rd) D_out <= rd_word;
      if (wr_commit) begin
        case (off_q)
          REG_DATA:    if (fifo_full) ovf <= 1'b1;
          REG_STATUS: begin
            if (D_in[ST_OVF]) ovf <= 1'b0;
            if (D_in[ST_UNF]) unf <= 1'b0;
          end
          REG_CTRL:    irq_en  <= D_in[CTRL_IRQ_EN];
          REG_SCRATCH: scratch <= D_in;
          default:     ;
        endcase
      end
      if (fifo_pop && fifo_empty) unf <= 1'b1;
      IRQ <= irq_en & ~fifo_empty;
    end
  end

  isa_target_fifo #(
    .WIDTH(16),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .din  (D_in),
    .head (fifo_head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_isa_io_target.sv
// Directed, table-driven bench for isa_io_target with hand-written timing and reset sequences.
module tb_isa_io_target;

  logic        clk;
  logic        reset;
  logic [15:0] A;
  logic [15:0] D_in;
  logic [15:0] D_out;
  logic        D_oe;
  logic        IOW_n;
  logic        IOR_n;
  logic        AEN;
  logic        IRQ;

  int checks;
  int errors;

  isa_io_target #(
    .BASE_ADDR (16'h0220),
    .FIFO_DEPTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .D_in (D_in),
    .D_out(D_out),
    .D_oe (D_oe),
    .IOW_n(IOW_n),
    .IOR_n(IOR_n),
    .AEN  (AEN),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    bit          aen;
    bit          exp_oe;
    logic [15:0] exp_data;
    bit          exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input bit aen);
    @(posedge clk); #1;
    A = addr; D_in = data; AEN = aen; IOW_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 IOW_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 AEN = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input bit aen, output logic [15:0] data,
                         output bit oe, output bit oe_after);
    @(posedge clk); #1;
    A = addr; AEN = aen; IOR_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    oe   = D_oe;
    data = D_out;
    IOR_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    oe_after = D_oe;
    AEN = 1'b0;
  endtask

  function automatic vec_t w(input logic [15:0] addr, input logic [15:0] data, input bit aen,
                             input bit irq);
    vec_t v;
    v = '{wr: 1'b1, addr: addr, data: data, aen: aen, exp_oe: 1'b0, exp_data: '0,
          exp_irq: irq};
    return v;
  endfunction

  function automatic vec_t r(input logic [15:0] addr, input bit aen, input bit oe,
                             input logic [15:0] exp, input bit irq);
    vec_t v;
    v = '{wr: 1'b0, addr: addr, data: '0, aen: aen, exp_oe: oe, exp_data: exp,
          exp_irq: irq};
    return v;
  endfunction

  initial begin
    logic [15:0] rdata;
    bit          oe;
    bit          oe_after;
    bit          oe_seen;

    checks = 0;
    errors = 0;

    vecs.push_back(r(16'h0221, 0, 1, 16'h0100, 0));
    vecs.push_back(w(16'h0223, 16'hA5C3, 0, 0));
    vecs.push_back(r(16'h0223, 0, 1, 16'hA5C3, 0));
    vecs.push_back(r(16'h0230, 0, 0, 16'h0000, 0));
    vecs.push_back(r(16'h0221, 1, 0, 16'h0000, 0));
    vecs.push_back(w(16'h0222, 16'h0001, 0, 0));
    vecs.push_back(r(16'h0222, 0, 1, 16'h0001, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(w(16'h0220, 16'(i), 0, 1));
    vecs.push_back(w(16'h0220, 16'h0009, 0, 1));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0608, 1));
    for (int i = 1; i <= 8; i++) vecs.push_back(r(16'h0220, 0, 1, 16'(i), (i != 8)));
    vecs.push_back(r(16'h0220, 0, 1, 16'h0000, 0));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0D00, 0));
    vecs.push_back(w(16'h0221, 16'h0800, 0, 0));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0500, 0));
    vecs.push_back(w(16'h0221, 16'h0400, 0, 0));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0100, 0));
    vecs.push_back(w(16'h0220, 16'h0011, 0, 1));
    vecs.push_back(w(16'h0220, 16'h0022, 0, 1));
    vecs.push_back(w(16'h0220, 16'h0033, 0, 1));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0003, 1));
    vecs.push_back(w(16'h0222, 16'h0002, 0, 0));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0100, 0));
    vecs.push_back(r(16'h0222, 0, 1, 16'h0000, 0));
    vecs.push_back(w(16'h0220, 16'h0044, 1, 0));
    vecs.push_back(r(16'h0221, 0, 1, 16'h0100, 0));

    reset = 1'b1; A = '0; D_in = '0; AEN = 1'b0; IOW_n = 1'b1; IOR_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_doe", 16'(D_oe), 16'h0000);
    check("reset_irq", 16'(IRQ), 16'h0000);
    check("reset_dout", D_out, 16'h0000);

    // Read latency: D_oe after the third edge, drop three edges after release.
    @(posedge clk); #1;
    A = 16'h0221; IOR_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("lat_oe_e2", 16'(D_oe), 16'h0000);
    @(posedge clk);
    #1 check("lat_oe_e3", 16'(D_oe), 16'h0001);
    check("lat_dout_e3", D_out, 16'h0100);
    @(posedge clk); #1 IOR_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("lat_rel_e2", 16'(D_oe), 16'h0001);
    @(posedge clk);
    #1 check("lat_rel_e3", 16'(D_oe), 16'h0000);
    repeat (5) @(posedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].aen);
      end else begin
        do_read(vecs[i].addr, vecs[i].aen, rdata, oe, oe_after);
        check($sformatf("vec%0d_oe", i), 16'(oe), 16'(vecs[i].exp_oe));
        if (vecs[i].exp_oe) check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
        check($sformatf("vec%0d_oe_rel", i), 16'(oe_after), 16'h0000);
      end
      check($sformatf("vec%0d_irq", i), 16'(IRQ), 16'(vecs[i].exp_irq));
    end

    // Both strobes together must not be decoded.
    @(posedge clk); #1;
    A = 16'h0223; D_in = 16'h1234; IOR_n = 1'b0; IOW_n = 1'b0;
    oe_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (D_oe) oe_seen = 1'b1;
    end
    IOR_n = 1'b1; IOW_n = 1'b1;
    repeat (6) @(posedge clk);
    check("both_strobes_oe", 16'(oe_seen), 16'h0000);
    do_read(16'h0223, 0, rdata, oe, oe_after);
    check("both_strobes_scratch", rdata, 16'hA5C3);

    // Reset in the middle of a read, strobe held across reset release.
    do_write(16'h0222, 16'h0001, 0);
    do_write(16'h0220, 16'h0055, 0);
    @(posedge clk); #1;
    A = 16'h0223; IOR_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("midrd_oe_before", 16'(D_oe), 16'h0001);
    @(negedge clk); #2 reset = 1'b1;
    #1 check("midrd_oe_async", 16'(D_oe), 16'h0000);
    check("midrd_irq_async", 16'(IRQ), 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    oe_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (D_oe) oe_seen = 1'b1;
    end
    check("held_strobe_ignored", 16'(oe_seen), 16'h0000);
    IOR_n = 1'b1;
    repeat (6) @(posedge clk);
    do_read(16'h0223, 0, rdata, oe, oe_after);
    check("post_reset_oe", 16'(oe), 16'h0001);
    check("post_reset_scratch", rdata, 16'h0000);
    do_read(16'h0221, 0, rdata, oe, oe_after);
    check("post_reset_status", rdata, 16'h0100);
    check("post_reset_irq", 16'(IRQ), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_io_target.md
# isa_io_target

ISA I/O responder that sits on the card-side end of the bus driven by the SuperIO initiator: it decodes I/O read/write strobe cycles at a fixed base address and serves a four-register window. The window is backed by a loopback FIFO, status and control registers, and an interrupt line. It gives the initiator a known, self-checking target on the FPGA for bring-up and regression, independent of the real CT2960 card.

## Interface
Parameters:
- BASE_ADDR, 16'h0220, I/O base; window decoded on A[15:2] == BASE_ADDR[15:2], offset = A[1:0]
- FIFO_DEPTH, 8, loopback FIFO entries; power of two, 2..128

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high
- A  in  16  ISA address
- D_in  in  16  ISA data, sampled on writes
- D_out  out  16  read data; reset 16'h0000
- D_oe  out  1  drive enable for D at top-level tristate; reset 0
- IOW_n  in  1  I/O write strobe, active-low, asynchronous to clk
- IOR_n  in  1  I/O read strobe, active-low, asynchronous to clk
- AEN  in  1  high = DMA cycle; all decode suppressed
- IRQ  out  1  active-high interrupt request; reset 0

## Operation
- IOW_n and IOR_n each pass through a 2-flop synchronizer. Synchronizer flops reset to deasserted (1).
  - Assertion edge = synced value goes 1→0.
  - Release edge = synced value goes 0→1.
- A hit requires all of the following, evaluated on the assertion edge:
  - A[15:2] matches BASE_ADDR[15:2]
  - AEN = 0
  - only one strobe asserted
- A and the offset are latched on the assertion edge.
- FSM states:
  - IDLE: on a read hit → RD; on a write hit → WR. Both strobes asserted, a miss, or AEN = 1 → stay IDLE with no side effects.
  - RD: D_oe = 1 and D_out holds the selected register, captured at entry. On IOR release → IDLE, D_oe = 0, and side effects apply.
  - WR: on IOW release, D_in is sampled and the write is committed → IDLE.
- Registers:
  - Offset 0, DATA: write pushes D_in into the FIFO; if the FIFO is full, the push is dropped and OVF is set. Read returns the FIFO head, and the pop happens at read release; if the FIFO is empty, the read returns 0 and UNF is set.
  - Offset 1, STATUS (read-only except W1C):
    - [7:0] count
    - [8] empty
    - [9] full
    - [10] OVF, sticky
    - [11] UNF, sticky
    - [15:12] 0
    - Writing 1 to bit 10 or 11 clears that bit.
  - Offset 2, CTRL:
    - [0] irq_en, read/write
    - [1] flush: write 1 empties the FIFO; self-clearing, reads as 0
    - other bits read as 0
  - Offset 3, SCRATCH: 16-bit read/write.
- IRQ is registered: IRQ = irq_en & !empty.
- Boundary cases:
  - A flush and a push in the same commit cannot coincide (different offsets). A flush on the same cycle as a pop: flush wins, count = 0.
  - Count arithmetic is width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - A strobe already asserted when reset releases is ignored until it deasserts.
  - Reset mid-cycle: D_oe drops to 0 immediately, FSM → IDLE, FIFO empty, all registers 0.

## Timing
- Read: IOR_n falls at edge 0. The synced assertion is seen at edge 2. D_oe and D_out are valid after edge 3, giving 3 clk of latency (60 ns at 50 MHz).
- D_oe falls 3 clk after IOR_n rises.
- Write: commit takes place 3 clk after IOW_n rises. Register and FIFO state are visible to the next read cycle.
- IRQ updates 1 clk after a commit changes empty or irq_en.
- Strobe constraints: minimum asserted width 4 clk; minimum gap between cycles 4 clk. Shorter pulses are not required to be decoded.

## Structure
- Package isa_target_pkg holds:
  - register offsets: REG_DATA = 0, REG_STATUS = 1, REG_CTRL = 2, REG_SCRATCH = 3
  - STATUS bit positions
  - the FSM state enum {IDLE, RD, WR}
- Sub-module isa_target_fifo: synchronous FIFO, parameterized by width and depth.
  - Inputs: push, pop, flush.
  - Outputs: head, count, empty, full.
  - Push when full and pop when empty are ignored inside the FIFO; OVF/UNF are flagged by the parent.
- Synchronizers, decode, FSM and registers live in the top module.

## Test plan
- Reset, then read STATUS → 16'h0100 (empty); D_oe = 0 outside the strobe; IRQ = 0.
- Write SCRATCH 16'hA5C3, then read it → 16'hA5C3. A read at base 16'h0230 → D_oe never asserts.
- Set irq_en, write DATA 16'h0001..16'h0008 → IRQ rises after the first write. A 9th write is dropped and STATUS → 16'h0608. Eight DATA reads return 1..8 in order, and IRQ falls after the last pop.
- Read DATA on an empty FIFO → 16'h0000 and UNF set. Write STATUS 16'h0800 → UNF cleared.
- Push 3 entries, write CTRL 16'h0002 → count 0. Then a DATA write with AEN = 1 → count stays 0.
- Assert reset while in RD → D_oe = 0 in the same cycle. IOR_n held low across reset release → no response until a new strobe arrives.
